// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack handshake, formats load data
// and owns the MEM/WB pipeline register feeding writeback.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] cout_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        reg_wren_i,
  input  logic [4:0]  dest_reg_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] result_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] cout_o,
  output logic [1:0]  wb_sel_o,
  output logic        reg_wren_o,
  output logic [4:0]  w_dest_reg_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic        r_kill;

  // Request held while the access is in flight
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [3:0]  r_dmem_be;
  logic [31:0] r_dmem_wdata;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_is_load;
  logic [31:0] r_op_result;
  logic [31:0] r_op_cout;
  logic [1:0]  r_op_wb_sel;
  logic        r_op_reg_wren;
  logic [4:0]  r_op_dest;
  logic [31:0] r_buf;

  // MEM/WB register
  logic        r_wb_valid;
  logic [31:0] r_result;
  logic [31:0] r_mem_data;
  logic [31:0] r_cout;
  logic [1:0]  r_wb_sel;
  logic        r_reg_wren;
  logic [4:0]  r_dest;
  logic        r_misalign;
  logic        r_bus_err;

  logic        w_is_mem;
  logic        w_misalign;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  assign w_is_mem   = mem_rd_i | mem_wr_i;
  assign w_misalign = ((mem_size_i == 2'b01) & alu_result_i[0]) |
                      (mem_size_i[1] & (|alu_result_i[1:0]));
  assign w_accept   = (r_state == StIdle) & valid_i & ~stall_i & ~flush_i;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    unique case (mem_size_i)
      2'b00: begin
        w_wdata = {4{store_data_i[7:0]}};
        w_be    = 4'b0001 << alu_result_i[1:0];
      end
      2'b01: begin
        w_wdata = {2{store_data_i[15:0]}};
        w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = store_data_i;
        w_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_byte = dmem_rdata_i[7:0];
    unique case (r_addr_lo)
      2'd0: w_byte = dmem_rdata_i[7:0];
      2'd1: w_byte = dmem_rdata_i[15:8];
      2'd2: w_byte = dmem_rdata_i[23:16];
      default: w_byte = dmem_rdata_i[31:24];
    endcase
    w_half = r_addr_lo[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (r_size)
      2'b00:   w_load_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_fmt = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_fmt = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_kill        <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_be     <= '0;
      r_dmem_wdata  <= '0;
      r_addr_lo     <= '0;
      r_size        <= '0;
      r_signed      <= 1'b0;
      r_is_load     <= 1'b0;
      r_op_result   <= '0;
      r_op_cout     <= '0;
      r_op_wb_sel   <= '0;
      r_op_reg_wren <= 1'b0;
      r_op_dest     <= '0;
      r_buf         <= '0;
      r_wb_valid    <= 1'b0;
      r_result      <= '0;
      r_mem_data    <= '0;
      r_cout        <= '0;
      r_wb_sel      <= '0;
      r_reg_wren    <= 1'b0;
      r_dest        <= '0;
      r_misalign    <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      // Bubble by default; only a stall without flush holds MEM/WB
      if (flush_i || !stall_i) begin
        r_wb_valid <= 1'b0;
        r_result   <= '0;
        r_mem_data <= '0;
        r_cout     <= '0;
        r_wb_sel   <= '0;
        r_reg_wren <= 1'b0;
        r_dest     <= '0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (w_is_mem && !w_misalign) begin
              r_state       <= StWait;
              r_cnt         <= '0;
              r_kill        <= 1'b0;
              r_dmem_req    <= 1'b1;
              r_dmem_we     <= mem_wr_i;
              r_dmem_addr   <= {alu_result_i[31:2], 2'b00};
              r_dmem_be     <= w_be;
              r_dmem_wdata  <= w_wdata;
              r_addr_lo     <= alu_result_i[1:0];
              r_size        <= mem_size_i;
              r_signed      <= mem_signed_i;
              r_is_load     <= mem_rd_i & ~mem_wr_i;
              r_op_result   <= alu_result_i;
              r_op_cout     <= cout_i;
              r_op_wb_sel   <= wb_sel_i;
              r_op_reg_wren <= reg_wren_i;
              r_op_dest     <= dest_reg_i;
            end else begin
              r_wb_valid <= 1'b1;
              r_result   <= alu_result_i;
              r_cout     <= cout_i;
              r_wb_sel   <= wb_sel_i;
              r_reg_wren <= reg_wren_i & ~w_is_mem;
              r_dest     <= dest_reg_i;
              r_misalign <= w_is_mem;
            end
          end
        end
        StWait: begin
          if (flush_i) r_kill <= 1'b1;
          if (dmem_ack_i) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_buf      <= r_is_load ? w_load_fmt : '0;
            r_state    <= (r_kill || flush_i) ? StIdle : StDone;
          end else if (r_cnt == LastCnt) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_bus_err  <= 1'b1;
            r_state    <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          if (flush_i) begin
            r_state <= StIdle;
          end else if (!stall_i) begin
            r_wb_valid <= 1'b1;
            r_result   <= r_op_result;
            r_mem_data <= r_buf;
            r_cout     <= r_op_cout;
            r_wb_sel   <= r_op_wb_sel;
            r_reg_wren <= r_op_reg_wren;
            r_dest     <= r_op_dest;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign stall_o      = stall_i | (r_state != StIdle);
  assign dmem_req_o   = r_dmem_req;
  assign dmem_we_o    = r_dmem_we;
  assign dmem_addr_o  = r_dmem_addr;
  assign dmem_be_o    = r_dmem_be;
  assign dmem_wdata_o = r_dmem_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign result_o     = r_result;
  assign mem_data_o   = r_mem_data;
  assign cout_o       = r_cout;
  assign wb_sel_o     = r_wb_sel;
  assign reg_wren_o   = r_reg_wren;
  assign w_dest_reg_o = r_dest;
  assign misalign_o   = r_misalign;
  assign bus_err_o    = r_bus_err;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads/stores, misalign, timeout,
// flush and stall interactions, asynchronous reset mid-access.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i, stall_i, valid_i, mem_rd_i, mem_wr_i, mem_signed_i, reg_wren_i;
  logic [1:0]  mem_size_i, wb_sel_i;
  logic [31:0] alu_result_i, store_data_i, cout_i, dmem_rdata_i;
  logic [4:0]  dest_reg_i;
  logic        dmem_ack_i;
  logic        stall_o, dmem_req_o, dmem_we_o, wb_valid_o, reg_wren_o, misalign_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, result_o, mem_data_o, cout_o;
  logic [3:0]  dmem_be_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  w_dest_reg_o;

  int n_total = 0;
  int n_pass  = 0;

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
    .mem_signed_i(mem_signed_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .cout_i(cout_i), .wb_sel_i(wb_sel_i), .reg_wren_i(reg_wren_i), .dest_reg_i(dest_reg_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
    .result_o(result_o), .mem_data_o(mem_data_o), .cout_o(cout_o), .wb_sel_o(wb_sel_o),
    .reg_wren_o(reg_wren_o), .w_dest_reg_o(w_dest_reg_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; mem_rd_i = 0; mem_wr_i = 0; mem_size_i = 2'b00; mem_signed_i = 0;
    reg_wren_i = 0; wb_sel_i = 2'b00; dest_reg_i = 0; alu_result_i = 0; store_data_i = 0;
    cout_i = 0;
  endtask

  initial begin
    rst_n_i = 0; flush_i = 0; stall_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    idle_inputs();
    step(); step();
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_reg_wren", reg_wren_o, 0);
    chk("rst_result", result_o, 0);
    rst_n_i = 1;
    step();

    // ALU op
    valid_i = 1; alu_result_i = 32'h1234; wb_sel_i = 2'b00; reg_wren_i = 1; dest_reg_i = 5;
    cout_i = 32'hC0;
    step();
    chk("alu_wb_valid", wb_valid_o, 1);
    chk("alu_result", result_o, 32'h1234);
    chk("alu_reg_wren", reg_wren_o, 1);
    chk("alu_dest", w_dest_reg_o, 5);
    chk("alu_cout", cout_o, 32'hC0);
    chk("alu_no_req", dmem_req_o, 0);
    idle_inputs();
    step();
    chk("bubble_wb_valid", wb_valid_o, 0);

    // Signed byte load, ack in third WAIT cycle
    valid_i = 1; mem_rd_i = 1; mem_size_i = 2'b00; mem_signed_i = 1; alu_result_i = 32'h103;
    reg_wren_i = 1; dest_reg_i = 7; wb_sel_i = 2'b01;
    step();
    idle_inputs();
    chk("lb_req", dmem_req_o, 1);
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_be", dmem_be_o, 4'b1000);
    chk("lb_we", dmem_we_o, 0);
    chk("lb_stall", stall_o, 1);
    chk("lb_wb_bubble", wb_valid_o, 0);
    step();
    step();
    chk("lb_req_held", dmem_req_o, 1);
    chk("lb_addr_held", dmem_addr_o, 32'h100);
    dmem_ack_i = 1; dmem_rdata_i = 32'h80AABBCC;
    step();
    dmem_ack_i = 0; dmem_rdata_i = 0;
    chk("lb_done_stall", stall_o, 1);
    chk("lb_done_req", dmem_req_o, 0);
    chk("lb_done_wb", wb_valid_o, 0);
    step();
    chk("lb_wb_valid", wb_valid_o, 1);
    chk("lb_mem_data", mem_data_o, 32'hFFFFFF80);
    chk("lb_result", result_o, 32'h103);
    chk("lb_reg_wren", reg_wren_o, 1);
    chk("lb_dest", w_dest_reg_o, 7);
    chk("lb_wb_sel", wb_sel_o, 2'b01);
    chk("lb_stall_rel", stall_o, 0);

    // Half store, ack in first WAIT cycle
    valid_i = 1; mem_wr_i = 1; mem_size_i = 2'b01; alu_result_i = 32'h202;
    store_data_i = 32'h0000BEEF;
    step();
    idle_inputs();
    chk("sh_we", dmem_we_o, 1);
    chk("sh_be", dmem_be_o, 4'b1100);
    chk("sh_wdata", dmem_wdata_o, 32'hBEEFBEEF);
    chk("sh_addr", dmem_addr_o, 32'h200);
    dmem_ack_i = 1; dmem_rdata_i = 32'hDEADDEAD;
    step();
    dmem_ack_i = 0;
    step();
    chk("sh_wb_valid", wb_valid_o, 1);
    chk("sh_mem_data", mem_data_o, 0);
    chk("sh_result", result_o, 32'h202);

    // Ack outside WAIT is ignored
    dmem_ack_i = 1;
    step();
    dmem_ack_i = 0;
    chk("stray_ack_stall", stall_o, 0);
    chk("stray_ack_req", dmem_req_o, 0);

    // Misaligned word load
    valid_i = 1; mem_rd_i = 1; mem_size_i = 2'b10; alu_result_i = 32'h301; reg_wren_i = 1;
    dest_reg_i = 9;
    step();
    idle_inputs();
    chk("mis_pulse", misalign_o, 1);
    chk("mis_no_req", dmem_req_o, 0);
    chk("mis_reg_wren", reg_wren_o, 0);
    chk("mis_wb_valid", wb_valid_o, 1);
    chk("mis_dest", w_dest_reg_o, 9);
    step();
    chk("mis_pulse_end", misalign_o, 0);

    // Timeout with TIMEOUT_CYCLES=4
    valid_i = 1; mem_rd_i = 1; mem_size_i = 2'b10; alu_result_i = 32'h400; reg_wren_i = 1;
    step();
    idle_inputs();
    chk("to_req_c1", dmem_req_o, 1);
    step(); step(); step();
    chk("to_req_c4", dmem_req_o, 1);
    chk("to_no_err_yet", bus_err_o, 0);
    step();
    chk("to_req_drop", dmem_req_o, 0);
    chk("to_bus_err", bus_err_o, 1);
    chk("to_stall_rel", stall_o, 0);
    chk("to_wb_bubble", wb_valid_o, 0);
    step();
    chk("to_bus_err_end", bus_err_o, 0);

    // Flush during WAIT, then ack
    valid_i = 1; mem_rd_i = 1; mem_size_i = 2'b10; alu_result_i = 32'h500; reg_wren_i = 1;
    dest_reg_i = 3;
    step();
    idle_inputs();
    flush_i = 1;
    step();
    flush_i = 0;
    chk("fl_req_held", dmem_req_o, 1);
    dmem_ack_i = 1; dmem_rdata_i = 32'h11223344;
    step();
    dmem_ack_i = 0;
    chk("fl_skip_done", stall_o, 0);
    chk("fl_req_drop", dmem_req_o, 0);
    step();
    chk("fl_wb_valid", wb_valid_o, 0);
    chk("fl_reg_wren", reg_wren_o, 0);
    chk("fl_mem_data", mem_data_o, 0);

    // Stall at ack: unsigned half load from upper lane
    valid_i = 1; mem_rd_i = 1; mem_size_i = 2'b01; alu_result_i = 32'h602; reg_wren_i = 1;
    dest_reg_i = 4;
    step();
    idle_inputs();
    stall_i = 1; dmem_ack_i = 1; dmem_rdata_i = 32'h80017FFF;
    step();
    dmem_ack_i = 0;
    chk("st_done_stall", stall_o, 1);
    step();
    chk("st_done_held", wb_valid_o, 0);
    chk("st_done_req", dmem_req_o, 0);
    stall_i = 0;
    step();
    chk("st_wb_valid", wb_valid_o, 1);
    chk("st_mem_data", mem_data_o, 32'h00008001);
    chk("st_dest", w_dest_reg_o, 4);
    chk("st_stall_rel", stall_o, 0);

    // Downstream stall holds MEM/WB; flush overrides stall
    stall_i = 1; valid_i = 1; alu_result_i = 32'h777; reg_wren_i = 1;
    step();
    chk("hold_result", result_o, 32'h602);
    chk("hold_wb_valid", wb_valid_o, 1);
    flush_i = 1;
    step();
    flush_i = 0; stall_i = 0;
    idle_inputs();
    chk("flush_over_stall", wb_valid_o, 0);
    chk("flush_reg_wren", reg_wren_o, 0);

    // Asynchronous reset mid-access
    valid_i = 1; mem_wr_i = 1; mem_size_i = 2'b10; alu_result_i = 32'h800;
    step();
    idle_inputs();
    chk("ar_req_before", dmem_req_o, 1);
    #2 rst_n_i = 0;
    #1;
    chk("ar_req_drop", dmem_req_o, 0);
    chk("ar_stall", stall_o, 0);
    step();
    rst_n_i = 1;
    step();
    chk("ar_idle", stall_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Sits between execute and writeback.
- Issues loads and stores to data memory over a req/ack handshake, then formats load data (byte/half/word, sign or zero extend).
- Stalls upstream while a memory access is outstanding.
- Owns the MEM/WB pipeline register that drives the writeback stage's result, mem_data, cout, wb_sel, reg_wren and dest-register inputs.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles without dmem_ack_i before the access aborts with bus error; range 1..255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  asynchronous reset, active-low
- flush_i  in  1  kill the instruction in this stage and in MEM/WB
- stall_i  in  1  downstream hold; MEM/WB must not change
- valid_i  in  1  execute stage presents an instruction
- mem_rd_i  in  1  instruction is a load
- mem_wr_i  in  1  instruction is a store
- mem_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- mem_signed_i  in  1  sign-extend load data
- alu_result_i  in  32  ALU result, also the effective address
- store_data_i  in  32  store source register
- cout_i  in  32  carry/aux result, passed through
- wb_sel_i  in  2  writeback select, passed through
- reg_wren_i  in  1  register write enable, passed through
- dest_reg_i  in  5  destination register
- stall_o  out  1  upstream must hold its outputs
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  memory accepts the write or returns read data this cycle
- dmem_rdata_i  in  32  read data, valid when dmem_ack_i is high
- wb_valid_o  out  1  MEM/WB holds a live instruction
- result_o  out  32  registered alu_result
- mem_data_o  out  32  registered formatted load data
- cout_o  out  32  registered cout
- wb_sel_o  out  2  registered wb_sel
- reg_wren_o  out  1  registered reg_wren, forced 0 for bubbles
- w_dest_reg_o  out  5  registered dest_reg
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: access timed out

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, timeout counter 0, all outputs 0.
- States: IDLE, WAIT, DONE.
- stall_o = stall_i OR state != IDLE.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.

IDLE, when stall_i is low and flush_i is low:
- Non-memory op: latch into MEM/WB. One-cycle latency; wb_valid_o = valid_i.
- Aligned memory op: latch the request into internal registers and go to WAIT. MEM/WB loads a bubble (wb_valid_o=0, reg_wren_o=0).
- Misaligned memory op: pulse misalign_o. Instruction enters MEM/WB with reg_wren_o=0 and wb_valid_o=1. No request is issued.

WAIT:
- dmem_req_o=1, address/be/wdata/we stable until ack.
- Counter increments each cycle. On dmem_ack_i: capture formatted rdata into a holding buffer and go to DONE.
- Counter reaching TIMEOUT_CYCLES without ack: drop the request, pulse bus_err_o, return to IDLE. The op retires as a bubble.

DONE:
- When stall_i is low, move the buffered op into MEM/WB (wb_valid_o=1; mem_data_o = buffer for loads, 0 for stores) and return to IDLE.
- Earliest completion: ack in the first WAIT cycle gives MEM/WB valid 2 cycles after accept.

Store lanes:
- byte: wdata = {4{sd[7:0]}}, be = 0001 << addr[1:0]
- half: wdata = {2{sd[15:0]}}, be = addr[1] ? 1100 : 0011
- word: wdata = sd, be = 1111

Load format:
- Select the lane by addr[1:0] (byte) or addr[1] (half).
- Extend per mem_signed_i.

stall_i high:
- MEM/WB holds all values, including the bubble.
- WAIT still completes into DONE; DONE waits.

flush_i:
- MEM/WB is cleared to a bubble next edge.
- In IDLE, no accept.
- In WAIT, the request is held until ack or timeout (no retraction), then the op is discarded and the state goes to IDLE, skipping DONE. A kill flag records this.
- In DONE, the buffer is discarded and the state goes to IDLE.
- flush_i has priority over stall_i for MEM/WB clearing.

General:
- dmem_ack_i while not in WAIT is ignored.
- Reset mid-access returns to IDLE immediately and drops dmem_req_o.

Test Plan:
- ALU op, alu_result_i=0x1234, wb_sel_i=00, reg_wren_i=1, dest 5 -> next cycle wb_valid_o=1, result_o=0x1234, reg_wren_o=1, w_dest_reg_o=5, no dmem_req_o.
- Signed byte load, addr 0x103, rdata 0x80AABBCC, ack after 3 WAIT cycles -> dmem_addr_o=0x100, be=1000, stall_o high through DONE, mem_data_o=0xFFFFFF80.
- Half store, addr 0x202, sd=0x0000BEEF -> dmem_we_o=1, be=1100, wdata=0xBEEFBEEF; wb_valid_o=1 with mem_data_o=0.
- Word load to addr 0x301 -> misalign_o pulses one cycle, no dmem_req_o, reg_wren_o=0.
- Load with ack withheld, TIMEOUT_CYCLES=4 -> dmem_req_o drops after 4 WAIT cycles, bus_err_o pulses once, state IDLE, stall_o released.
- Two cases:
  - flush_i during WAIT then ack -> no MEM/WB update, reg_wren_o=0.
  - stall_i high at ack -> DONE held until stall_i low, then mem_data_o updates.
